counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one external up-counter (ports enabled, value, active-low clear) between NREQ requesters.
- Round-robin arbitration; each requester asks for a run of `len` counting cycles.
- For the granted requester: clears the counter, enables it for exactly `len` cycles, then pulses done (or err on watchdog timeout).
- Sits between requester logic and the counter instance; it is the only driver of the counter's enable and clear.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter width, equal to `len` width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester run request, level; held until done/err or dropped to abort.
- len  input  NREQ*WIDTH  per-requester run length; slice i = len[i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot owner of the counter; all zero when idle.
- done  output  NREQ  one-cycle pulse on the owner's bit at normal completion.
- err  output  NREQ  one-cycle pulse on the owner's bit at watchdog timeout.
- cnt_enabled  output  1  drives the counter's enabled input.
- cnt_clr_n  output  1  drives the counter's active-low clear.
- cnt_value  input  WIDTH  counter's value output.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0) values:
  - state=IDLE
  - grant=0, done=0, err=0
  - cnt_enabled=0, cnt_clr_n=1
  - rr pointer=0 (requester 0 has highest priority first)
  - len_q=0, watchdog=0
- FSM states: IDLE, CLEAR, RUN, FINISH.
- IDLE:
  - If req!=0, pick the first set bit searching from rr pointer upward with wrap.
  - Latch its len slice into len_q.
  - At the next edge: grant=onehot(winner), cnt_clr_n=0, state=CLEAR.
  - If req==0, stay in IDLE.
- CLEAR (one cycle, counter being cleared):
  - At the next edge: cnt_clr_n=1.
  - If len_q==0, go to FINISH (no enable cycles).
  - Otherwise cnt_enabled=1, watchdog=0, state=RUN.
- RUN:
  - cnt_enabled=1; watchdog increments each cycle.
  - If cnt_value==len_q-1: at the next edge cnt_enabled=0, state=FINISH. The counter then holds len_q, with exactly len_q enabled cycles.
  - If watchdog reaches 2^WIDTH+1 before the match: cnt_enabled=0, err[owner]=1 for one cycle, grant=0, rr pointer=owner+1, state=IDLE.
- FINISH:
  - done[owner]=1 for one cycle, grant=0.
  - rr pointer = owner+1 mod NREQ.
  - At the next edge: state=IDLE.
- Abort:
  - If req[owner] drops in CLEAR or RUN: next edge cnt_enabled=0, cnt_clr_n=1, grant=0, no done/err, rr pointer=owner+1, state=IDLE.
  - The counter keeps its partial value.
- Input handling:
  - len is sampled only in IDLE; later changes are ignored until the next grant.
  - Requests from other requesters during a run are ignored until IDLE; no queueing beyond the level req.
- Handover timing:
  - Minimum gap between consecutive grants is one IDLE cycle; grant is never asserted in IDLE or FINISH.
  - Simultaneous requests resolve by rr pointer only; a requester re-asserting right after its own done loses to any other pending req.
- Invariants:
  - cnt_enabled=1 implies grant!=0.
  - grant is always one-hot or zero.
  - done and err are never both set.
- Reset mid-operation: all outputs return immediately to their reset values; the counter is released with enabled=0.

Test Plan:
- Single requester: req[0]=1, len[0]=5 → grant=0001 one cycle after req; cnt_clr_n low 1 cycle; cnt_enabled high exactly 5 cycles; cnt_value=5 at done[0] pulse; grant=0 afterwards.
- Round robin: req=1111 held, all len=2 → grants in order 0,1,2,3,0; each done pulse is one cycle; one IDLE cycle between grants.
- Zero length: req[2]=1, len[2]=0 → clear pulse, cnt_enabled never high, done[2] two cycles after grant.
- Abort: req[1]=1, len[1]=9, drop req[1] after 3 enabled cycles → cnt_enabled low next edge; no done/err; cnt_value=3 held; next pending requester granted.
- Watchdog: cnt_value tied to 0, req[0]=1, len[0]=4 → err[0] pulse after 17 RUN cycles; done stays 0; grant released.
- Reset mid-run: rst_n=0 during RUN with len=8 → grant, cnt_enabled, done and err all 0 immediately; after release, req[3] gets served before req[0] only if rr pointer=0 rules it, i.e. req=1001 → grant=0001 first.

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters,
// clearing it, enabling it for a requested number of cycles, then signalling done/err.
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] len_i,
    output logic [NREQ-1:0]       grant_o,
    output logic [NREQ-1:0]       done_o,
    output logic [NREQ-1:0]       err_o,
    output logic                  cnt_enabled_o,
    output logic                  cnt_clr_n_o,
    input  logic [WIDTH-1:0]      cnt_value_i
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = WIDTH + 1;
    // A healthy run needs at most 2^WIDTH enabled cycles; one more means the counter is stuck.
    localparam logic [WDW-1:0] WD_LIMIT = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic             en_q, en_d;
    logic             clr_n_q, clr_n_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             found_s;
    logic [IW-1:0]    win_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            ptr_after = '0;
        end else begin
            ptr_after = idx + IW'(1);
        end
    endfunction

    // Winner search: first pending request at or after the round-robin pointer, with wrap.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_i[(int'(rr_q) + k) % NREQ]) begin
                found_s = 1'b1;
                win_s   = IW'((int'(rr_q) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        en_d    = en_q;
        clr_n_d = 1'b1;
        rr_d    = rr_q;
        owner_d = owner_q;
        len_d   = len_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (found_s) begin
                    grant_d = onehot(win_s);
                    clr_n_d = 1'b0;
                    owner_d = win_s;
                    len_d   = len_i[int'(win_s)*WIDTH +: WIDTH];
                    state_d = CLEAR;
                end else begin
                    grant_d = '0;
                end
            end
            CLEAR: begin
                if (!req_i[owner_q]) begin
                    en_d    = 1'b0;
                    grant_d = '0;
                    rr_d    = ptr_after(owner_q);
                    state_d = IDLE;
                end else if (len_q == '0) begin
                    grant_d = '0;
                    state_d = FINISH;
                end else begin
                    en_d    = 1'b1;
                    wd_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over completion; the counter keeps its partial value.
                if (!req_i[owner_q]) begin
                    en_d    = 1'b0;
                    grant_d = '0;
                    rr_d    = ptr_after(owner_q);
                    state_d = IDLE;
                end else if (cnt_value_i == (len_q - WIDTH'(1))) begin
                    en_d    = 1'b0;
                    grant_d = '0;
                    state_d = FINISH;
                end else if (wd_q == WD_LIMIT) begin
                    en_d    = 1'b0;
                    grant_d = '0;
                    err_d   = onehot(owner_q);
                    rr_d    = ptr_after(owner_q);
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            FINISH: begin
                grant_d = '0;
                en_d    = 1'b0;
                done_d  = onehot(owner_q);
                rr_d    = ptr_after(owner_q);
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
            rr_q    <= '0;
            owner_q <= '0;
            len_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            clr_n_q <= clr_n_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
        end
    end

    assign grant_o       = grant_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign cnt_enabled_o = en_q;
    assign cnt_clr_n_o   = clr_n_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a cycle-timeline reference model plus a real counter,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_counter_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int WD_RUN_CYCLES = (1 << WIDTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant, done, err;
    logic                  cnt_enabled, cnt_clr_n;
    logic [WIDTH-1:0]      cval = '0;
    logic [WIDTH-1:0]      cnt_value;
    logic                  tie_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: session timeline measured in cycles since the grant.
    int m_rr, m_own, m_len, m_t;
    bit m_active, m_fin;
    logic [NREQ-1:0] e_grant, e_done, e_err;
    logic e_en, e_clr;

    counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .len_i         (len),
        .grant_o       (grant),
        .done_o        (done),
        .err_o         (err),
        .cnt_enabled_o (cnt_enabled),
        .cnt_clr_n_o   (cnt_clr_n),
        .cnt_value_i   (cnt_value)
    );

    always #5 clk = ~clk;

    // The shared external counter (synchronous active-low clear).
    always @(posedge clk) begin
        if (!cnt_clr_n) cval <= '0;
        else if (cnt_enabled) cval <= cval + 1'b1;
    end
    assign cnt_value = tie_zero ? '0 : cval;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_own = 0; m_len = 0; m_t = 0;
        m_active = 1'b0; m_fin = 1'b0;
        e_grant = '0; e_done = '0; e_err = '0; e_en = 1'b0; e_clr = 1'b1;
    endtask

    // Compute what the outputs must be after the coming edge from this cycle's inputs.
    task automatic model_step();
        logic [NREQ-1:0] r;
        int v, pick;
        r = req;
        v = int'(cnt_value);
        e_done = '0; e_err = '0; e_clr = 1'b1;
        if (m_fin) begin
            e_done = NREQ'(1) << m_own;
            m_rr = (m_own + 1) % NREQ;
            m_fin = 1'b0;
            e_grant = '0; e_en = 1'b0;
        end else if (!m_active) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && r[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
            e_en = 1'b0;
            e_grant = '0;
            if (pick >= 0) begin
                m_own = pick;
                m_len = int'(len[pick*WIDTH +: WIDTH]);
                m_t = 0;
                m_active = 1'b1;
                e_grant = NREQ'(1) << pick;
                e_clr = 1'b0;
            end
        end else if (!r[m_own]) begin
            m_active = 1'b0;
            m_rr = (m_own + 1) % NREQ;
            e_grant = '0; e_en = 1'b0;
        end else if (m_t == 0) begin
            if (m_len == 0) begin
                m_active = 1'b0; m_fin = 1'b1; e_grant = '0;
            end else begin
                m_t = 1; e_en = 1'b1;
            end
        end else if (v == m_len - 1) begin
            m_active = 1'b0; m_fin = 1'b1; e_grant = '0; e_en = 1'b0;
        end else if (m_t == WD_RUN_CYCLES) begin
            m_active = 1'b0;
            m_rr = (m_own + 1) % NREQ;
            e_err = NREQ'(1) << m_own;
            e_grant = '0; e_en = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_all();
        chk("grant", int'(grant), int'(e_grant));
        chk("done", int'(done), int'(e_done));
        chk("err", int'(err), int'(e_err));
        chk("cnt_enabled", int'(cnt_enabled), int'(e_en));
        chk("cnt_clr_n", int'(cnt_clr_n), int'(e_clr));
    endtask

    // One clock: model advances on this cycle's inputs, DUT is checked at the next falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        req = '0;
        tie_zero = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] g);
        idx_of = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) idx_of = i;
    endfunction

    initial begin
        int lat, en_n, dval, gi, di, got, done_seen, run_n;
        int order[$];
        logic [NREQ-1:0] prev_g;
        req = '0; len = '0; tie_zero = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_clr_n", int'(cnt_clr_n), 1);
        rst_n = 1'b1;

        // Single requester, len 5.
        len = '0; len[0 +: WIDTH] = 4'd5; req = 4'b0001;
        lat = -1; en_n = 0; dval = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (lat < 0 && grant[0]) lat = i + 1;
            if (cnt_enabled) en_n++;
            if (done[0]) begin dval = int'(cnt_value); req = '0; break; end
        end
        chk("single_grant_latency", lat, 1);
        chk("single_en_cycles", en_n, 5);
        chk("single_value_at_done", dval, 5);
        cyc();
        chk("single_grant_released", int'(grant), 0);

        // Round robin with all requesters at len 2.
        do_reset();
        len = {4'd2, 4'd2, 4'd2, 4'd2}; req = 4'b1111;
        prev_g = '0;
        for (int i = 0; i < 80 && order.size() < 5; i++) begin
            cyc();
            if (grant != '0 && prev_g == '0) order.push_back(idx_of(grant));
            prev_g = grant;
        end
        chk("rr_grant_count", order.size(), 5);
        if (order.size() == 5) begin
            chk("rr_order0", order[0], 0);
            chk("rr_order1", order[1], 1);
            chk("rr_order2", order[2], 2);
            chk("rr_order3", order[3], 3);
            chk("rr_order4", order[4], 0);
        end
        drain(4);

        // Zero length on requester 2.
        do_reset();
        len = '0; req = 4'b0100;
        gi = -1; di = -1; en_n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (gi < 0 && grant[2]) gi = i;
            if (cnt_enabled) en_n++;
            if (done[2]) begin di = i; req = '0; break; end
        end
        chk("zero_done_delay", di - gi, 2);
        chk("zero_en_never", en_n, 0);
        drain(2);

        // Abort after 3 enabled cycles; requester 3 is waiting next.
        do_reset();
        len = '0; len[1*WIDTH +: WIDTH] = 4'd9; len[3*WIDTH +: WIDTH] = 4'd3; req = 4'b0010;
        en_n = 0;
        for (int i = 0; i < 30 && en_n < 3; i++) begin
            cyc();
            if (cnt_enabled) en_n++;
        end
        chk("abort_reached_3", en_n, 3);
        req = 4'b1000;
        cyc();
        chk("abort_en_low", int'(cnt_enabled), 0);
        chk("abort_value_held", int'(cnt_value), 3);
        chk("abort_no_done_err", int'({done, err}), 0);
        cyc();
        chk("abort_next_grant", int'(grant), 8);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (done[3]) break;
        end
        drain(2);

        // Watchdog: counter stuck at zero.
        do_reset();
        tie_zero = 1'b1;
        len = '0; len[0 +: WIDTH] = 4'd4; req = 4'b0001;
        run_n = 0; got = 0; done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (cnt_enabled) run_n++;
            if (done != '0) done_seen = 1;
            if (err[0]) begin got = 1; break; end
        end
        chk("wd_err_seen", got, 1);
        chk("wd_run_cycles", run_n, 17);
        chk("wd_no_done", done_seen, 0);
        chk("wd_grant_released", int'(grant), 0);
        drain(2);
        tie_zero = 1'b0;

        // Reset in the middle of a run.
        do_reset();
        len = '0; len[0 +: WIDTH] = 4'd8; len[3*WIDTH +: WIDTH] = 4'd1; req = 4'b0001;
        en_n = 0;
        for (int i = 0; i < 30 && en_n < 3; i++) begin
            cyc();
            if (cnt_enabled) en_n++;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_en", int'(cnt_enabled), 0);
        chk("rst_done_err", int'({done, err}), 0);
        chk("rst_clr_n", int'(cnt_clr_n), 1);
        model_reset();
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rst_rr_grant", int'(grant), 1);
        drain(3);

        // Randomized traffic: toggling requests, changing lengths, occasional stuck counter.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 3) == 0)
                len[$urandom_range(0, NREQ-1)*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            if ($urandom_range(0, 199) == 0) tie_zero = ~tie_zero;
            cyc();
        end
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
